tt_um_seq_signed_unsigned_4x4_multiplier: RTL and testbench



---
 rtl/tt_mult_pkg.sv | 20 ++
 rtl/mult4_seq_core.sv | 95 +++++++++
 rtl/tt_um_seq_signed_unsigned_4x4_multiplier.sv | 41 ++++
 tb/tb_tt_um_seq_signed_unsigned_4x4_multiplier.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mult_pkg.sv
// Shared types and constants for the sequential 4x4 signed/unsigned multiplier tile.
package tt_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OPW = 4;
  localparam int PW  = 8;

  localparam int UIO_START  = 0;
  localparam int UIO_SIGNED = 1;
  localparam int UIO_BUSY   = 2;
  localparam int UIO_DONE   = 3;

  localparam logic [7:0] UIO_OE_MASK = 8'h0C;

endpackage

// File: rtl/mult4_seq_core.sv
// FSM, step counter and shift-add datapath: one partial product per enabled clock.
module mult4_seq_core
  import tt_mult_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          start_i,
  input  logic          signed_i,
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [PW-1:0]  product_o
);

  state_t         state_q, state_d;
  logic [1:0]     step_q, step_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic           signed_q, signed_d;

  logic [PW-1:0]  aExt;
  logic [PW-1:0]  addend;
  logic [PW-1:0]  accStep;

  // Two's-complement weight of B[3] is negative, so the last signed step subtracts.
  always_comb begin
    aExt    = signed_q ? {{(PW-OPW){a_q[OPW-1]}}, a_q} : {{(PW-OPW){1'b0}}, a_q};
    addend  = aExt << step_q;
    accStep = acc_q;
    if (b_q[step_q]) begin
      if (signed_q && (step_q == 2'd3)) accStep = acc_q - addend;
      else                              accStep = acc_q + addend;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          a_d      = a_i;
          b_d      = b_i;
          signed_d = signed_i;
          acc_d    = '0;
          step_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d  = accStep;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          prod_d  = accStep;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      step_q   <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
    end else if (en_i) begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
    end
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign product_o = prod_q;

endmodule

// File: rtl/tt_um_seq_signed_unsigned_4x4_multiplier.sv
// TinyTapeout wrapper: pin packing, enable gating and the fixed uio direction mask.
module tt_um_seq_signed_unsigned_4x4_multiplier
  import tt_mult_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic busy;
  logic done;
  logic unusedPins;

  mult4_seq_core u_core (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (ena),
    .start_i   (uio_in[UIO_START]),
    .signed_i  (uio_in[UIO_SIGNED]),
    .a_i       (ui_in[3:0]),
    .b_i       (ui_in[7:4]),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (uo_out)
  );

  always_comb begin
    uio_out           = '0;
    uio_out[UIO_BUSY] = busy;
    uio_out[UIO_DONE] = done;
  end

  assign uio_oe     = UIO_OE_MASK;
  assign unusedPins = ^uio_in[7:2];

endmodule

// File: tb/tb_tt_um_seq_signed_unsigned_4x4_multiplier.sv
// Directed self-checking bench for the sequential 4x4 multiplier tile.
module tb_tt_um_seq_signed_unsigned_4x4_multiplier;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  tt_um_seq_signed_unsigned_4x4_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives operands with start at a falling edge and returns 1 time unit after the accepting edge.
  task automatic startOp(input logic [3:0] a, input logic [3:0] b, input logic sgn);
    @(negedge clk);
    ui_in  = {b, a};
    uio_in = {6'b0, sgn, 1'b1};
    @(posedge clk);
    #1;
    uio_in[0] = 1'b0;
  endtask

  // Counts rising edges until done is seen; returns 99 when the bound expires.
  task automatic waitDone(output int cycles);
    cycles = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (uio_out[3]) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_uo_out got=%h exp=00", uo_out);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_uio_out got=%h exp=00", uio_out);
    end
    checks++;
    if (uio_oe !== 8'h0C) begin
      errors++;
      $display("[TB] FAIL reset_uio_oe got=%h exp=0c", uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max;
    int cycles;
    startOp(4'hF, 4'hF, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      checks++;
      if (uio_out !== 8'h04 || uio_oe !== 8'h0C) begin
        errors++;
        $display("[TB] FAIL umax_busy_phase%0d uio_out=%h uio_oe=%h exp=04/0c", n, uio_out, uio_oe);
      end
      if (n < 4) begin
        @(posedge clk);
        #1;
      end
    end
    waitDone(cycles);
    checks++;
    if (cycles !== 1) begin
      errors++;
      $display("[TB] FAIL umax_latency got=%0d exp=1 edge after busy phase", cycles);
    end
    checks++;
    if (uo_out !== 8'hE1 || uio_out !== 8'h08 || uio_oe !== 8'h0C) begin
      errors++;
      $display("[TB] FAIL umax_result uo=%h uio_out=%h uio_oe=%h exp=e1/08/0c", uo_out, uio_out, uio_oe);
    end
  endtask

  task automatic test_signed;
    logic [3:0] va [4] = '{4'h8, 4'h7, 4'h3, 4'h3};
    logic [3:0] vb [4] = '{4'h8, 4'h8, 4'hF, 4'hF};
    logic       vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] vp [4] = '{8'h40, 8'hC8, 8'hFD, 8'h2D};
    int cycles;
    for (int i = 0; i < 4; i++) begin
      startOp(va[i], vb[i], vs[i]);
      waitDone(cycles);
      checks++;
      if (cycles !== 4 || uo_out !== vp[i]) begin
        errors++;
        $display("[TB] FAIL mode_vec%0d a=%h b=%h s=%0d uo=%h cycles=%0d exp=%h/4", i, va[i], vb[i], vs[i], uo_out, cycles, vp[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int cycles;
    startOp(4'h5, 4'h3, 1'b0);
    @(negedge clk);
    ui_in  = 8'hFF;
    uio_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    uio_in = 8'h00;
    waitDone(cycles);
    checks++;
    if (cycles !== 2 || uo_out !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL ignore_start uo=%h cycles=%0d exp=0f/2", uo_out, cycles);
    end
  endtask

  task automatic test_ena_stall;
    int cycles;
    startOp(4'h6, 4'h7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (uio_out !== 8'h04 || uo_out !== 8'h0F) begin
        errors++;
        $display("[TB] FAIL ena_hold%0d uio_out=%h uo=%h exp=04/0f", n, uio_out, uo_out);
      end
    end
    ena = 1'b1;
    waitDone(cycles);
    checks++;
    if (cycles !== 2 || uo_out !== 8'h2A) begin
      errors++;
      $display("[TB] FAIL ena_result uo=%h cycles=%0d exp=2a/2", uo_out, cycles);
    end
  endtask

  task automatic test_mid_reset;
    int cycles;
    startOp(4'h9, 4'h9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_reset uio_out=%h uo=%h exp=00/00", uio_out, uo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (uio_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL post_reset_idle uio_out=%h exp=00", uio_out);
    end
    startOp(4'h2, 4'h2, 1'b0);
    waitDone(cycles);
    checks++;
    if (cycles !== 4 || uo_out !== 8'h04) begin
      errors++;
      $display("[TB] FAIL post_reset_op uo=%h cycles=%0d exp=04/4", uo_out, cycles);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] expUio;
    logic [7:0] expUo;
    @(negedge clk);
    ui_in  = {4'h3, 4'h2};
    uio_in = 8'h01;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      expUio = (n % 5 == 0) ? 8'h08 : 8'h04;
      expUo  = (n < 5) ? 8'h04 : 8'h06;
      checks++;
      if (uio_out !== expUio || uo_out !== expUo) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d uio_out=%h uo=%h exp=%h/%h", n, uio_out, uo_out, expUio, expUo);
      end
    end
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_ignore_start();
    test_ena_stall();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
